// File: rtl/microc_stack.sv
// microc_stack: parametrised single-cycle microcontroller datapath with a
// 16-entry register file, ALU with zero/carry flags, program counter and a
// hardware return-address stack with sticky overflow/underflow flags.
// Ports:
//   clk, reset             : clock and synchronous active-high reset.
//   instr, pc, opcode      : program-memory data in, program address out,
//                            opcode field out for the external control unit.
//   s_inc, s_inm, we3, wez, op, push, pop : per-cycle control strobes.
//   z, c                   : registered zero/carry flags.
//   sp, ovf, unf           : stack depth and sticky stack error flags.
module microc_stack #(
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              instr,
  output logic [AW-1:0]            pc,
  input  logic                     s_inc,
  input  logic                     s_inm,
  input  logic                     we3,
  input  logic                     wez,
  input  logic [2:0]               op,
  input  logic                     push,
  input  logic                     pop,
  output logic [5:0]               opcode,
  output logic                     z,
  output logic                     c,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     ovf,
  output logic                     unf
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  // Instruction fields
  logic [3:0]    ra1, ra2, wa3;
  logic [AW-1:0] tgt;

  assign ra1    = instr[11:8];
  assign ra2    = instr[7:4];
  assign wa3    = instr[3:0];
  assign tgt    = instr[AW-1:0];
  assign opcode = instr[15:10];

  // Register file
  logic [DW-1:0] regs_q [0:15];
  logic [DW-1:0] rd1, rd2, wd;

  // r0 is hard-wired to zero on the read side; writes to it are dropped.
  assign rd1 = (ra1 == 4'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 4'd0) ? '0 : regs_q[ra2];

  // ALU
  logic [DW-1:0] res;
  logic          cout;

  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (op)
      3'b000: res = rd1;
      3'b001: res = ~rd1;
      3'b010: {cout, res} = {1'b0, rd1} + {1'b0, rd2};
      3'b011: begin
        res  = rd1 - rd2;
        cout = (rd1 < rd2);  // borrow
      end
      3'b100: res = rd1 & rd2;
      3'b101: res = rd1 | rd2;
      3'b110: res = '0 - rd1;
      default: res = '0 - rd2;
    endcase
  end

  assign wd = s_inm ? DW'(instr[11:4]) : res;

  // PC / return stack state
  logic [AW-1:0] pc_q, pc_d, pc_inc, top;
  logic [SW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          z_q, c_q;
  logic          stk_we;
  logic [AW-1:0] stk_q [0:DEPTH-1];
  logic [IW-1:0] top_idx;
  logic          full, empty;

  assign pc_inc  = pc_q + AW'(1);
  assign full    = (sp_q == SW'(DEPTH));
  assign empty   = (sp_q == '0);
  // Low bits of sp minus one; correct also when sp == DEPTH (low bits 0).
  assign top_idx = sp_q[IW-1:0] - IW'(1);
  assign top     = stk_q[top_idx];

  // Next-PC / stack control. Pop dominates push; a simultaneous push is
  // silently ignored and raises no error.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    stk_we = 1'b0;
    if (pop) begin
      if (!empty) begin
        pc_d = top;
        sp_d = sp_q - SW'(1);
      end else begin
        pc_d  = pc_inc;
        unf_d = 1'b1;
      end
    end else if (push) begin
      pc_d = tgt;
      if (!full) begin
        stk_we = 1'b1;
        sp_d   = sp_q + SW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      pc_d = s_inc ? pc_inc : tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (wez) begin
        z_q <= (res == '0);
        c_q <= cout;
      end
      if (we3 && (wa3 != 4'd0)) regs_q[wa3] <= wd;
    end
  end

  // Stack contents need no reset; sp alone defines validity.
  always_ff @(posedge clk) begin
    if (stk_we && !reset) stk_q[sp_q[IW-1:0]] <= pc_inc;
  end

  assign pc  = pc_q;
  assign sp  = sp_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
  assign z   = z_q;
  assign c   = c_q;

endmodule
